// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller (32 lines x 128 bits).
// Latency: a read hit returns data in the request cycle. A miss or a write stalls for 1 + N cycles (N = memory cycles up to m_ready).
// Backpressure: the CPU holds its request while stall is high. The memory port holds m_rd/m_wr until m_ready.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   cpu_rd/cpu_wr    CPU load/store request (store wins if both are set)
//   cpu_addr         CPU word address: offset [1:0], index [6:2], tag [ADDR_W-1:7]
//   cpu_wdata        store data, forwarded unchanged to m_wdata
//   cpu_rdata        word of c_rd selected by cpu_addr[1:0] (combinational)
//   stall            CPU must hold its request while high
//   c_r_addrs        data-array read index
//   c_w_addrs        data-array write address: index and word offset
//   c_we, w_h        data-array write enable; w_h=1 writes one CPU word, w_h=0 writes the m_rdata line
//   c_rd             data-array read line
//   m_rd, m_wr       memory line read / memory word write
//   m_addr           memory word address (line-aligned for reads)
//   m_wdata          memory write data
//   m_rdata          fill line; the data array takes it directly, so this block does not use it
//   m_ready          memory completion; only meaningful while m_rd or m_wr is high
//   rd_hits          saturating count of read hits
//   rd_misses        saturating count of read misses
module cache_controller #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              stall,
   output logic [4:0]        c_r_addrs,
   output logic [6:0]        c_w_addrs,
   output logic              c_we,
   output logic              w_h,
   input  logic [127:0]      c_rd,
   output logic              m_rd,
   output logic              m_wr,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_wdata,
   input  logic [127:0]      m_rdata,
   input  logic              m_ready,
   output logic [15:0]       rd_hits,
   output logic [15:0]       rd_misses
);

   localparam int TAG_W = ADDR_W - 7;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2,
      S_WDONE = 2'd3
   } state_t;

   state_t state_q, state_d;

   // Tag/valid array
   logic [31:0]      valid_q;
   logic [TAG_W-1:0] tag_q [32];

   logic [4:0]        idx;
   logic [TAG_W-1:0]  tag;
   logic              hit;
   logic [ADDR_W-1:0] line_addr;

   // Per-cycle strobes from the output decoder
   logic fill_done;
   logic hit_inc;
   logic miss_inc;

   logic [15:0] rd_hits_q, rd_hits_d;
   logic [15:0] rd_misses_q, rd_misses_d;

   // The fill line goes straight from memory into the data array.
   logic unused_m_rdata;
   assign unused_m_rdata = ^m_rdata;

   assign idx       = cpu_addr[6:2];
   assign tag       = cpu_addr[ADDR_W-1:7];
   assign hit       = valid_q[idx] && (tag_q[idx] == tag);
   assign line_addr = {cpu_addr[ADDR_W-1:2], 2'b00};

   assign c_r_addrs = idx;
   assign c_w_addrs = cpu_addr[6:0];
   assign m_wdata   = cpu_wdata;
   assign cpu_rdata = c_rd[{cpu_addr[1:0], 5'b00000} +: 32];

   assign rd_hits   = rd_hits_q;
   assign rd_misses = rd_misses_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (cpu_wr) begin
               state_d = S_WRITE;
            end else if (cpu_rd && !hit) begin
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            if (m_ready) begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            if (m_ready) begin
               state_d = S_WDONE;
            end
         end
         S_WDONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode. Outputs are forced to their idle values while rst is
   // high. A request the CPU still holds during reset therefore does not
   // raise stall or bump a counter.
   always_comb begin
      stall     = 1'b0;
      m_rd      = 1'b0;
      m_wr      = 1'b0;
      c_we      = 1'b0;
      w_h       = 1'b0;
      m_addr    = cpu_addr;
      fill_done = 1'b0;
      hit_inc   = 1'b0;
      miss_inc  = 1'b0;
      if (!rst) begin
         unique case (state_q)
            S_IDLE: begin
               if (cpu_wr) begin
                  stall = 1'b1;
               end else if (cpu_rd) begin
                  if (hit) begin
                     hit_inc = 1'b1;
                  end else begin
                     stall    = 1'b1;
                     miss_inc = 1'b1;
                  end
               end
            end
            S_FILL: begin
               m_rd   = 1'b1;
               stall  = 1'b1;
               m_addr = line_addr;
               // The line write and the tag/valid update land together,
               // so a partially filled line is never marked valid.
               if (m_ready) begin
                  c_we      = 1'b1;
                  fill_done = 1'b1;
               end
            end
            S_WRITE: begin
               m_wr  = 1'b1;
               stall = 1'b1;
               // No-write-allocate: a write miss leaves the array alone.
               if (m_ready && hit) begin
                  c_we = 1'b1;
                  w_h  = 1'b1;
               end
            end
            S_WDONE: begin
               // One quiet cycle. The CPU sees stall low and retires the store.
            end
            default: begin
            end
         endcase
      end
   end

   // Tag/valid array update on fill completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < 32; i++) begin
            tag_q[i] <= '0;
         end
      end else if (fill_done) begin
         valid_q[idx] <= 1'b1;
         tag_q[idx]   <= tag;
      end
   end

   // Saturating performance counters
   always_comb begin
      rd_hits_d   = rd_hits_q;
      rd_misses_d = rd_misses_q;
      if (hit_inc && (rd_hits_q != 16'hFFFF)) begin
         rd_hits_d = rd_hits_q + 16'd1;
      end
      if (miss_inc && (rd_misses_q != 16'hFFFF)) begin
         rd_misses_d = rd_misses_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_hits_q   <= '0;
         rd_misses_q <= '0;
      end else begin
         rd_hits_q   <= rd_hits_d;
         rd_misses_q <= rd_misses_d;
      end
   end

   // The memory port never carries a read and a write at once.
   a_mem_excl: assert property (@(posedge clk) disable iff (rst) !(m_rd && m_wr));

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller.
// Latency: not applicable. The bench models the data array, main memory and a tag/counter reference.
// Backpressure: the bench acts as the CPU and the memory, and drives m_ready after a chosen latency.
module tb_cache_controller;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_rd, cpu_wr;
   logic [AW-1:0] cpu_addr;
   logic [31:0]   cpu_wdata, cpu_rdata;
   logic          stall;
   logic [4:0]    c_r_addrs;
   logic [6:0]    c_w_addrs;
   logic          c_we, w_h;
   logic [127:0]  c_rd;
   logic          m_rd, m_wr;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_wdata;
   logic [127:0]  m_rdata;
   logic          m_ready;
   logic [15:0]   rd_hits, rd_misses;

   cache_controller #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .stall(stall), .c_r_addrs(c_r_addrs), .c_w_addrs(c_w_addrs),
      .c_we(c_we), .w_h(w_h), .c_rd(c_rd), .m_rd(m_rd), .m_wr(m_wr),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
      .m_ready(m_ready), .rd_hits(rd_hits), .rd_misses(rd_misses)
   );

   always #5 clk = ~clk;

   // Data array: written on negedge, read combinationally
   logic [127:0] darr [32];
   assign c_rd = darr[c_r_addrs];
   always @(negedge clk) begin
      if (c_we) begin
         if (w_h) darr[c_w_addrs[6:2]][{c_w_addrs[1:0], 5'b00000} +: 32] <= cpu_wdata;
         else     darr[c_w_addrs[6:2]] <= m_rdata;
      end
   end

   // Main memory and the reference cache state
   logic [31:0] mem [1024];
   bit          rv [32];
   logic [2:0]  rt [32];
   int unsigned exp_hits, exp_misses;

   int n_vec = 0;
   int n_err = 0;

   function automatic int unsigned sat(input int unsigned v);
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         rv[i] = 1'b0;
         rt[i] = '0;
      end
      exp_hits   = 0;
      exp_misses = 0;
   endtask

   // One CPU access. The task is entered at posedge+1 and returns at posedge+1.
   task automatic access(input bit wr, input bit rd_too, input logic [9:0] a,
                         input logic [31:0] wd, input int lat);
      logic [4:0] i;
      logic [2:0] tg;
      logic [9:0] la;
      bit         h;
      i  = a[6:2];
      tg = a[9:7];
      la = {a[9:2], 2'b00};
      h  = rv[i] && (rt[i] == tg);
      cpu_addr  = a;
      cpu_wdata = wd;
      cpu_wr    = wr;
      cpu_rd    = wr ? rd_too : 1'b1;
      m_ready   = 1'b0;
      #6;
      if (!wr && h) begin
         chk("hit_stall", stall, 0);
         chk("hit_no_mrd", m_rd, 0);
         chk("hit_data", cpu_rdata, mem[a]);
         exp_hits = sat(exp_hits + 1);
         tick();
      end else begin
         chk("req_stall", stall, 1);
         chk("req_mem_quiet", {m_rd, m_wr}, 0);
         chk("req_cwe", c_we, 0);
         tick();
         for (int k = 1; k <= lat; k++) begin
            m_ready = (k == lat);
            m_rdata = {mem[la+3], mem[la+2], mem[la+1], mem[la]};
            #6;
            chk("busy_stall", stall, 1);
            if (wr) begin
               chk("wr_mwr", {m_rd, m_wr}, 2'b01);
               chk("wr_maddr", m_addr, a);
               chk("wr_mwdata", m_wdata, wd);
               chk("wr_cwe", c_we, (k == lat) && h);
               if (k == lat && h) chk("wr_wh", w_h, 1);
            end else begin
               chk("fill_mrd", {m_rd, m_wr}, 2'b10);
               chk("fill_maddr", m_addr, la);
               chk("fill_cwe", c_we, (k == lat));
               if (k == lat) chk("fill_wh", w_h, 0);
            end
            tick();
         end
         m_ready = 1'b0;
         if (wr) begin
            mem[a] = wd;
            // The single stall-free cycle after a write. A stray m_ready here must be ignored.
            cpu_wr  = 1'b0;
            cpu_rd  = 1'b0;
            m_ready = 1'b1;
            #6;
            chk("wdone_stall", stall, 0);
            chk("wdone_mem", {m_rd, m_wr}, 0);
            chk("wdone_cwe", c_we, 0);
            tick();
            m_ready = 1'b0;
         end else begin
            rv[i] = 1'b1;
            rt[i] = tg;
            exp_misses = sat(exp_misses + 1);
            exp_hits   = sat(exp_hits + 1);
            #6;
            chk("refill_stall", stall, 0);
            chk("refill_mrd", m_rd, 0);
            chk("refill_data", cpu_rdata, mem[a]);
            tick();
         end
      end
      // Idle cycle: a random stray m_ready must do nothing.
      cpu_rd  = 1'b0;
      cpu_wr  = 1'b0;
      m_ready = 1'($urandom);
      #6;
      chk("idle_stall", stall, 0);
      chk("idle_cwe", c_we, 0);
      chk("rd_hits", rd_hits, 16'(exp_hits));
      chk("rd_misses", rd_misses, 16'(exp_misses));
      tick();
      m_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      m_ready = 1'b0; m_rdata = '0;
      for (int w = 0; w < 1024; w++) mem[w] = $urandom;
      for (int l = 0; l < 32; l++) darr[l] = '0;
      model_reset();

      // Reset state
      #3;
      chk("rst_stall", stall, 0);
      chk("rst_mem", {m_rd, m_wr}, 0);
      chk("rst_cwe_wh", {c_we, w_h}, 0);
      chk("rst_cnt", {rd_hits, rd_misses}, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Directed sequence
      access(0, 0, 10'h005, 32'h0, 3);             // miss with fill on the 3rd cycle
      access(0, 0, 10'h006, 32'h0, 1);             // hit on the same line
      access(1, 0, 10'h005, 32'h1234_5678, 2);     // write hit
      access(0, 0, 10'h005, 32'h0, 1);             // re-read returns the new word
      chk("wr_through", mem[10'h005], 32'h1234_5678);
      access(1, 1, 10'h085, 32'hCAFE_F00D, 1);     // write miss, conflicting tag
      access(0, 0, 10'h005, 32'h0, 1);             // 0x005 still hits
      access(0, 0, 10'h085, 32'h0, 2);             // conflict fill
      access(0, 0, 10'h005, 32'h0, 4);             // 0x005 now misses

      // Reset in the middle of a fill
      access(0, 0, 10'h010, 32'h0, 1);             // cache 0x010
      cpu_addr = 10'h3F0; cpu_rd = 1'b1;
      #6; chk("mf_stall", stall, 1);
      tick();
      #6; chk("mf_mrd", m_rd, 1);
      tick();
      rst = 1'b1;
      #1;
      chk("mf_rst_mrd", m_rd, 0);
      chk("mf_rst_stall", stall, 0);
      chk("mf_rst_cnt", {rd_hits, rd_misses}, 0);
      model_reset();
      cpu_rd = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      access(0, 0, 10'h010, 32'h0, 2);             // previously cached address misses

      // Random accesses over 4 indices x 4 tags
      for (int n = 0; n < 200; n++) begin
         logic [9:0] ra;
         ra = {3'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom)};
         access(($urandom_range(0, 2) == 0), 1'($urandom), ra, $urandom, $urandom_range(1, 4));
      end

      // Hit counter saturation
      access(0, 0, 10'h021, 32'h0, 1);
      cpu_addr = 10'h021; cpu_rd = 1'b1;
      repeat (65540) tick();
      exp_hits = sat(exp_hits + 65540);
      cpu_rd = 1'b0;
      #6;
      chk("sat_hits", rd_hits, 16'hFFFF);
      chk("sat_model", rd_hits, 16'(exp_hits));
      tick();
      access(0, 0, 10'h021, 32'h0, 1);             // hit stays at 0xFFFF
      access(0, 0, 10'h3A1, 32'h0, 1);             // misses still count

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/cache_controller.md
# cache_controller

Direct-mapped, write-through, no-write-allocate controller for the 32-line × 128-bit data cache. It sits between the CPU memory-stage port and the cache data array, and drives the main-memory port. It holds the tag/valid array, detects hit/miss, sequences line fills and write-through transactions, and stalls the CPU while either is in progress.

## Interface
- ADDR_W, default 10. CPU word-address width; must be ≥ 8.
  - Offset = addr[1:0], index = addr[6:2], tag = addr[ADDR_W-1:7].
- clk  in  1  Clock. All state changes on posedge.
- rst  in  1  Asynchronous, active-high reset.
- cpu_rd  in  1  Load request.
- cpu_wr  in  1  Store request. Takes priority if asserted together with cpu_rd.
- cpu_addr  in  ADDR_W  Word address.
- cpu_wdata  in  32  Store data.
- cpu_rdata  out  32  Load data: the word of c_rd selected by cpu_addr[1:0]. Combinational.
- stall  out  1  CPU must hold its request while high.
- c_r_addrs  out  5  Read index to the data array; equals cpu_addr[6:2].
- c_w_addrs  out  7  Write address to the data array; equals cpu_addr[6:0].
- c_we  out  1  Data-array write enable.
- w_h  out  1  Selects the data-array write mode. 1 = single word from CPU data; 0 = full 128-bit line from m_rdata.
- c_rd  in  128  Data-array read line.
- m_rd  out  1  Memory line read.
- m_wr  out  1  Memory word write.
- m_addr  out  ADDR_W  Memory word address. Line-aligned ({tag,index,2'b00}) for reads; cpu_addr for writes.
- m_wdata  out  32  Equals cpu_wdata.
- m_rdata  in  128  Fill line. Routed externally to the data array's d_m_data.
- m_ready  in  1  Memory completion. Valid only while m_rd or m_wr is high.
- rd_hits, rd_misses  out  16 each  Saturating performance counters.

## Operation
- Tag array: 32 entries of {valid, tag}. Reset clears all valid bits.
- hit = valid[idx] && tag[idx] == cpu_addr tag bits. Computed combinationally from cpu_addr.
- FSM states: IDLE, FILL, WRITE, WDONE. All outputs are decoded from state plus current inputs.
- IDLE:
  - cpu_wr → stall=1. Next state WRITE.
  - cpu_rd && !hit → stall=1. Next state FILL. rd_misses increments.
  - cpu_rd && hit → stall=0. rd_hits increments; stay in IDLE.
  - No request → stall=0, no counter change.
- FILL:
  - m_rd=1, stall=1, m_addr line-aligned.
  - On m_ready: c_we=1, w_h=0 that cycle. At the posedge, valid[idx]=1 and tag[idx]=tag. Next state IDLE.
  - The re-evaluation in IDLE then hits: stall=0, and rd_hits increments for that same access.
- WRITE:
  - m_wr=1, stall=1.
  - On m_ready: if hit, c_we=1 and w_h=1 (word update). If miss, the cache is untouched. Next state WDONE.
- WDONE: stall=0, no memory or cache activity, no new request accepted. Next state IDLE.
- c_we is never high outside FILL/WRITE with m_ready=1. m_rd and m_wr are never both high.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - state=IDLE; stall=0; m_rd=m_wr=0; c_we=0; w_h=0.
  - All valid bits=0; both counters=0.
  - These take effect immediately on rst assertion, including mid-FILL or mid-WRITE; the pending transaction is abandoned.
- Read hit: zero stall cycles; cpu_rdata is valid in the request cycle.
- Read miss: stall cycles = 1 (IDLE detect) + N (FILL cycles up to and including m_ready). Data is returned in the following IDLE cycle.
- Write: stall cycles = 1 + N. Stall is low for exactly one cycle in WDONE.
- The data array writes on negedge, so c_we, w_h, c_w_addrs and m_rdata are held stable for the whole m_ready cycle.
- The fill write and the tag update land in the same cycle. No partial line is ever visible as valid.
- m_ready asserted in IDLE or WDONE is ignored.

## Test plan
- Reset, then read 0x005 with m_ready on the 3rd FILL cycle, m_rdata=0xDDDD_CCCC_BBBB_AAAA_… → stall high for 4 cycles, then cpu_rdata = word 1. rd_misses=1, rd_hits=1.
- Read 0x006 immediately after → stall=0, correct word 2 from the same line, no m_rd.
- Write 0x005=0x1234_5678 (hit) → m_wr with m_addr=0x005, c_we=1 and w_h=1 on the m_ready cycle, WDONE stall=0. A re-read returns 0x1234_5678 with no miss.
- Write 0x085 (same index, different tag, miss) → m_wr only, c_we stays 0. A subsequent read of 0x005 still hits.
- Read 0x085 (conflict) → FILL replaces the line; read 0x005 afterwards misses.
- Assert rst mid-FILL → m_rd drops the same cycle; a re-read of a previously cached address misses.
- Apply 65 540 read hits → rd_hits saturates at 0xFFFF.
